// File: rtl/data_mem_stage_pkg.sv
// Shared types and helpers for the MEM-stage data memory: access sizes, FSM
// encoding, request record and byte-lane helpers for the big-endian RAM.
package mem_pkg;

  localparam int WAIT_W = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  size;
    logic        se;
    logic [31:0] a;
    logic [31:0] di;
  } mem_req_t;

  // The reserved size code behaves as a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return off;
      SIZE_HALF: return {off[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  // Lane 3 of the mask is the lowest byte address (bits 31:24 of the word).
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b1000 >> off;
      SIZE_HALF: return off[1] ? 4'b0011 : 4'b1100;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] di);
    case (size)
      SIZE_BYTE: return {4{di[7:0]}};
      SIZE_HALF: return {2{di[15:0]}};
      default:   return di;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_stage_if.sv
// EX/MEM request fields in, load result and handshake out toward MEM/WB and
// the hazard unit.
interface data_mem_stage_if;
  logic        E;
  logic        RW;
  logic [1:0]  SIZE;
  logic        SE;
  logic [31:0] A;
  logic [31:0] DI;
  logic [31:0] DO;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (output E, RW, SIZE, SE, A, DI, input DO, ready, busy, err);
  modport slave  (input E, RW, SIZE, SE, A, DI, output DO, ready, busy, err);
endinterface

// File: rtl/data_mem_stage_load_align.sv
// Picks the byte/half out of a big-endian 32-bit word and sign/zero extends it.
// Purely combinational so the forwarding path can share it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        se,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[31:24];
    case (off)
      2'd0:    byte_v = word[31:24];
      2'd1:    byte_v = word[23:16];
      2'd2:    byte_v = word[15:8];
      default: byte_v = word[7:0];
    endcase
  end

  assign half_v = off[1] ? word[15:0] : word[31:16];

  always_comb begin
    data = word;
    case (size)
      SIZE_BYTE: data = {{24{se & byte_v[7]}}, byte_v};
      SIZE_HALF: data = {{16{se & half_v[15]}}, half_v};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_stage.sv
// MEM-stage data memory: big-endian byte RAM, byte/half/word access, wait-state FSM.
// Define MISALIGN_TRAP_EN to flag misaligned accesses on err instead of masking the address.
module data_mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_stage_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt;
  mem_req_t          acc;
  logic              accept, acc_go, trap, err_q;
  logic [1:0]        off;
  logic [3:0]        be;
  logic [ADDR_W-3:0] widx;
  logic [31:0]       rd_word, ld_data, st_lanes, do_q;
  logic [7:0]        mem [DEPTH];

  assign accept = bus.E && (state != ST_WAIT);

  // With no wait states the access happens on the acceptance edge straight from
  // the inputs; otherwise it replays the latched request on the last wait edge.
  generate
    if (WAIT_STATES == 0) begin : g_nowait
      assign acc_go = accept;
      assign acc    = {bus.RW, bus.SIZE, bus.SE, bus.A, bus.DI};
    end else begin : g_wait
      mem_req_t req_q;
      always_ff @(posedge clk) begin
        if (reset)       req_q <= '0;
        else if (accept) req_q <= {bus.RW, bus.SIZE, bus.SE, bus.A, bus.DI};
      end
      assign acc_go = (state == ST_WAIT) && (cnt == WAIT_W'(1));
      assign acc    = req_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (cnt == WAIT_W'(1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = accept ? ((WAIT_STATES == 0) ? ST_DONE : ST_WAIT) : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = misaligned(acc.size, acc.a[1:0]);
  assign off  = acc.a[1:0];
`else
  assign trap = 1'b0;
  assign off  = align_off(acc.size, acc.a[1:0]);
`endif

  assign widx     = acc.a[ADDR_W-1:2];
  assign be       = trap ? 4'b0000 : byte_en(acc.size, off);
  assign st_lanes = store_lanes(acc.size, acc.di);
  assign rd_word  = {mem[{widx, 2'd0}], mem[{widx, 2'd1}],
                     mem[{widx, 2'd2}], mem[{widx, 2'd3}]};

  wire unused_hi = ^acc.a[31:ADDR_W];

  load_align u_align (
    .word (rd_word),
    .off  (off),
    .size (acc.size),
    .se   (acc.se),
    .data (ld_data)
  );

  // RAM is not cleared on reset; reset only blocks a pending write.
  always_ff @(posedge clk) begin
    if (acc_go && acc.rw && !reset) begin
      if (be[3]) mem[{widx, 2'd0}] <= st_lanes[31:24];
      if (be[2]) mem[{widx, 2'd1}] <= st_lanes[23:16];
      if (be[1]) mem[{widx, 2'd2}] <= st_lanes[15:8];
      if (be[0]) mem[{widx, 2'd3}] <= st_lanes[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      do_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept)                cnt <= WAIT_W'(WAIT_STATES);
      else if (state == ST_WAIT) cnt <= cnt - WAIT_W'(1);
      if (acc_go) begin
        if (trap)         do_q <= '0;
        else if (!acc.rw) do_q <= ld_data;
        err_q <= trap;
      end
    end
  end

  assign bus.DO    = do_q;
  assign bus.ready = (state == ST_DONE);
  assign bus.busy  = (state == ST_WAIT);
  assign bus.err   = (state == ST_DONE) && err_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench: one zero-wait and one 3-wait-state instance, expectations
// queued at issue time and checked (data, err, completion cycle) on each ready.
module tb_data_mem_stage;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  data_mem_stage_if b0();
  data_mem_stage_if b3();

  data_mem_stage #(.ADDR_W(9), .WAIT_STATES(0)) u0 (.clk(clk), .reset(rst0), .bus(b0));
  data_mem_stage #(.ADDR_W(9), .WAIT_STATES(3)) u3 (.clk(clk), .reset(rst3), .bus(b3));

  typedef struct {
    logic [31:0] exp_do;
    logic        exp_err;
    int          at;
  } exp_t;

  exp_t        q0[$], q3[$];
  int          nchk = 0, nfail = 0;
  logic [31:0] last0 = '0, last3 = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst0 && b0.ready === 1'b1) begin
      if (q0.size() == 0) check("w0 spurious ready", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("w0 DO", b0.DO, e.exp_do);
        check("w0 err", {31'd0, b0.err}, {31'd0, e.exp_err});
        check("w0 ready cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst3 && b3.ready === 1'b1) begin
      if (q3.size() == 0) check("w3 spurious ready", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        check("w3 DO", b3.DO, e.exp_do);
        check("w3 err", {31'd0, b3.err}, {31'd0, e.exp_err});
        check("w3 ready cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Called at a negedge; holds E for one cycle, returns at the next negedge.
  task automatic acc0(input logic rw, input logic [1:0] sz, input logic se,
                      input logic [31:0] a, input logic [31:0] di,
                      input logic [31:0] exp_do, input logic exp_err);
    exp_t e;
    b0.E = 1'b1; b0.RW = rw; b0.SIZE = sz; b0.SE = se; b0.A = a; b0.DI = di;
    e.exp_do = exp_do; e.exp_err = exp_err; e.at = cyc + 1;
    q0.push_back(e);
    @(negedge clk);
    b0.E = 1'b0;
  endtask

  task automatic st0(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] di);
    acc0(1'b1, sz, 1'b0, a, di, last0, 1'b0);
  endtask

  task automatic ld0(input logic [1:0] sz, input logic se, input logic [31:0] a,
                     input logic [31:0] exp);
    acc0(1'b0, sz, se, a, 32'h0, exp, 1'b0);
    last0 = exp;
  endtask

  task automatic push3(input logic [31:0] exp_do, input int at);
    exp_t e;
    e.exp_do = exp_do; e.exp_err = 1'b0; e.at = at;
    q3.push_back(e);
  endtask

  task automatic set3(input logic rw, input logic [1:0] sz, input logic se,
                      input logic [31:0] a, input logic [31:0] di);
    b3.E = 1'b1; b3.RW = rw; b3.SIZE = sz; b3.SE = se; b3.A = a; b3.DI = di;
  endtask

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    b0.E = 0; b0.RW = 0; b0.SIZE = 0; b0.SE = 0; b0.A = 0; b0.DI = 0;
    b3.E = 0; b3.RW = 0; b3.SIZE = 0; b3.SE = 0; b3.A = 0; b3.DI = 0;
    repeat (2) @(negedge clk);
    check("rst w0 DO", b0.DO, 32'h0);
    check("rst w0 ready/busy/err", {29'd0, b0.ready, b0.busy, b0.err}, 32'h0);
    check("rst w3 DO", b3.DO, 32'h0);
    check("rst w3 ready/busy/err", {29'd0, b3.ready, b3.busy, b3.err}, 32'h0);
    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    // Zero wait states, back-to-back requests.
    st0(SIZE_WORD, 32'h10, 32'h11223344);
    ld0(SIZE_WORD, 1'b0, 32'h10, 32'h11223344);
    ld0(SIZE_BYTE, 1'b0, 32'h10, 32'h00000011);
    ld0(SIZE_HALF, 1'b0, 32'h12, 32'h00003344);
    ld0(SIZE_BYTE, 1'b1, 32'h13, 32'h00000044);
    ld0(SIZE_WORD, 1'b0, 32'h210, 32'h11223344);
    @(negedge clk);
    st0(SIZE_BYTE, 32'h20, 32'h12345680);
    ld0(SIZE_BYTE, 1'b1, 32'h20, 32'hFFFFFF80);
    ld0(SIZE_BYTE, 1'b0, 32'h20, 32'h00000080);
    st0(SIZE_HALF, 32'h22, 32'h00008001);
    ld0(SIZE_HALF, 1'b1, 32'h22, 32'hFFFF8001);
    ld0(SIZE_HALF, 1'b0, 32'h22, 32'h00008001);
    st0(SIZE_WORD, 32'h30, 32'hAABBCCDD);
    st0(SIZE_HALF, 32'h32, 32'h00001234);
    ld0(SIZE_WORD, 1'b0, 32'h30, 32'hAABB1234);
    ld0(2'b11, 1'b0, 32'h30, 32'hAABB1234);
    st0(SIZE_BYTE, 32'h31, 32'h0000005A);
    ld0(SIZE_WORD, 1'b0, 32'h30, 32'hAA5A1234);
`ifdef MISALIGN_TRAP_EN
    acc0(1'b1, SIZE_WORD, 1'b0, 32'h31, 32'h99887766, 32'h0, 1'b1);
    last0 = 32'h0;
    ld0(SIZE_WORD, 1'b0, 32'h30, 32'hAA5A1234);
`else
    st0(SIZE_WORD, 32'h31, 32'h99887766);
    ld0(SIZE_WORD, 1'b0, 32'h30, 32'h99887766);
`endif
    repeat (2) @(negedge clk);

    // Three wait states: busy window, ignored E in WAIT.
    set3(1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h55667788);
    push3(last3, cyc + 4);
    @(negedge clk); b3.E = 1'b0;
    check("w3 busy c1", {31'd0, b3.busy}, 32'd1);
    @(negedge clk);
    check("w3 busy c2", {31'd0, b3.busy}, 32'd1);
    set3(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0);
    @(negedge clk); b3.E = 1'b0;
    check("w3 busy c3", {31'd0, b3.busy}, 32'd1);
    @(negedge clk);
    check("w3 busy c4", {31'd0, b3.busy}, 32'd0);
    @(negedge clk);

    // E held through DONE: second access follows with no idle cycle.
    set3(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0);
    push3(32'h55667788, cyc + 4);
    repeat (4) @(negedge clk);
    set3(1'b0, SIZE_BYTE, 1'b1, 32'h41, 32'h0);
    push3(32'h00000066, cyc + 4);
    @(negedge clk); b3.E = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in WAIT aborts the pending store.
    set3(1'b1, SIZE_WORD, 1'b0, 32'h40, 32'hDEADBEEF);
    @(negedge clk); b3.E = 1'b0;
    @(negedge clk); rst3 = 1'b1;
    @(negedge clk);
    check("w3 abort busy/ready", {30'd0, b3.busy, b3.ready}, 32'd0);
    rst3 = 1'b0;
    @(negedge clk);
    set3(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0);
    push3(32'h55667788, cyc + 4);
    @(negedge clk); b3.E = 1'b0;
    repeat (6) @(negedge clk);

    check("w0 queue drained", 32'(q0.size()), 32'd0);
    check("w3 queue drained", 32'(q3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
